// File: rtl/vga_timing_gen.sv
// 800x600@60 Hz VGA timing source: free-running h/v counters decoded into a registered VGA bus plus frame/line strobes.
// Define VGA_TIMING_TEST_PATTERN_EN to drive colour bars in the active area instead of black.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  output logic [`VGA_BUS_SIZE-1:0] vga_bus_out,
  output logic                     frame_start,
  output logic                     line_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_BLNK_START = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_BLNK_START = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] r_h_cnt;
  logic [10:0] r_v_cnt;

  logic        w_h_last;
  logic        w_v_last;
  logic        w_hblnk;
  logic        w_hsync;
  logic        w_vblnk;
  logic        w_vsync;
  logic        w_frame_pos;
  logic        w_line_pos;
  logic [11:0] w_rgb;

  logic [10:0] r_hcount;
  logic [10:0] r_vcount;
  logic        r_hsync;
  logic        r_hblnk;
  logic        r_vsync;
  logic        r_vblnk;
  logic [11:0] r_rgb;
  logic        r_frame_start;
  logic        r_line_start;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  // Counters never reach the totals: the last value wraps straight back to zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (en) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? 11'd0 : r_v_cnt + 11'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 11'd1;
      end
    end
  end

  assign w_hblnk     = (r_h_cnt >= H_BLNK_START);
  assign w_hsync     = (r_h_cnt >= H_SYNC_START) && (r_h_cnt < H_SYNC_END);
  assign w_vblnk     = (r_v_cnt >= V_BLNK_START);
  assign w_vsync     = (r_v_cnt >= V_SYNC_START) && (r_v_cnt < V_SYNC_END);
  assign w_line_pos  = (r_h_cnt == 11'd0);
  assign w_frame_pos = w_line_pos && (r_v_cnt == 11'd0);

`ifdef VGA_TIMING_TEST_PATTERN_EN
  // Eight 128-pixel bars selected by h_cnt[9:7]; black whenever either blanking is active.
  always_comb begin
    w_rgb = 12'h000;
    if (!w_hblnk && !w_vblnk) begin
      case (r_h_cnt[9:7])
        3'd0:    w_rgb = 12'hFFF;
        3'd1:    w_rgb = 12'hFF0;
        3'd2:    w_rgb = 12'h0FF;
        3'd3:    w_rgb = 12'h0F0;
        3'd4:    w_rgb = 12'hF0F;
        3'd5:    w_rgb = 12'hF00;
        3'd6:    w_rgb = 12'h00F;
        default: w_rgb = 12'h000;
      endcase
    end
  end
`else
  assign w_rgb = 12'h000;
`endif

  // One register stage keeps every bus field aligned with the same counter snapshot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_hsync       <= 1'b0;
      r_hblnk       <= 1'b0;
      r_vsync       <= 1'b0;
      r_vblnk       <= 1'b0;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
    end else if (en) begin
      r_hcount      <= r_h_cnt;
      r_vcount      <= r_v_cnt;
      r_hsync       <= w_hsync;
      r_hblnk       <= w_hblnk;
      r_vsync       <= w_vsync;
      r_vblnk       <= w_vblnk;
      r_rgb         <= w_rgb;
      r_frame_start <= w_frame_pos;
      r_line_start  <= w_line_pos;
    end else begin
      // Frozen bus must not repeat a strobe when counting resumes.
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
    end
  end

  assign vga_bus_out = {r_hcount, r_hsync, r_hblnk, r_vcount, r_vsync, r_vblnk, r_rgb};
  assign frame_start = r_frame_start;
  assign line_start  = r_line_start;

endmodule
